// File: rtl/ff_select_sequencer_if.sv
// ff_select_sequencer_if: bundles the sequencer's board-control inputs, the datapath
// feedback bit T and every sequencer output.
//   start, abort  board controls (level)
//   T             datapath mux output fed back to the sequencer
//   dp_s_reset    synchronous reset to datapath flops
//   dp_X/Y/Z      counting stimulus (bits 2/1/0)
//   S1, S0        datapath select
//   busy, done    sequence status; done is a one-cycle pulse
//   signature     per-select sample of T
//   ones_count    saturating count of RUN cycles with T==1
// modport slave is the sequencer; modport master is whatever drives it (board/bench).
interface ff_select_sequencer_if;
  logic       start;
  logic       abort;
  logic       T;
  logic       dp_s_reset;
  logic       dp_X;
  logic       dp_Y;
  logic       dp_Z;
  logic       S1;
  logic       S0;
  logic       busy;
  logic       done;
  logic [3:0] signature;
  logic [7:0] ones_count;

  modport master (
    output start, abort, T,
    input  dp_s_reset, dp_X, dp_Y, dp_Z, S1, S0, busy, done, signature, ones_count
  );

  modport slave (
    input  start, abort, T,
    output dp_s_reset, dp_X, dp_Y, dp_Z, S1, S0, busy, done, signature, ones_count
  );
endinterface

// File: rtl/ff_select_sequencer.sv
// ff_select_sequencer: drives the flip-flop/mux test datapath. On start it pulses the
// datapath sync reset for one cycle, walks {S1,S0} through 00..11 holding each for DWELL
// cycles while counting X/Y/Z, and captures T into a 4-bit signature and a ones count.
//   clk      system clock, rising edge
//   a_reset  asynchronous reset, active-high
//   bus      ff_select_sequencer_if.slave (start/abort/T in, datapath drive and status out)
// Every output comes straight from a flop.
module ff_select_sequencer #(
  parameter int unsigned DWELL = 4  // cycles per select setting, 1..63
) (
  input logic                  clk,
  input logic                  a_reset,
  ff_select_sequencer_if.slave bus
);

  localparam logic [5:0] DwellLast = 6'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [5:0] dwell_q, dwell_d;
  logic [2:0] stim_q, stim_d;
  logic [3:0] sig_q, sig_d;
  logic [7:0] ones_q, ones_d;
  logic       s_reset_q, s_reset_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic dwell_end;
  logic run_end;
  logic go;

  assign dwell_end = (dwell_q == DwellLast);
  assign run_end   = dwell_end && (sel_q == 2'd3);
  // abort outside a run still suppresses a start seen on the same edge
  assign go        = bus.start && !bus.abort;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (go) state_d = StClear;
      StClear: state_d = bus.abort ? StIdle : StRun;
      StRun: begin
        if (bus.abort)   state_d = StIdle;
        else if (run_end) state_d = StDone;
      end
      StDone:  state_d = go ? StClear : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sel_d   = sel_q;
    dwell_d = dwell_q;
    stim_d  = stim_q;
    sig_d   = sig_q;
    ones_d  = ones_q;

    // The edge that leaves RUN (completion or abort) still samples T.
    if (state_q == StRun) begin
      stim_d = stim_q + 3'd1;
      if (bus.T && (ones_q != 8'd255)) ones_d = ones_q + 8'd1;
      if (dwell_end) begin
        sig_d[sel_q] = bus.T;
        dwell_d      = 6'd0;
        sel_d        = sel_q + 2'd1;
      end else begin
        dwell_d = dwell_q + 6'd1;
      end
    end

    // Select/stimulus only move inside RUN; everywhere else they sit at zero.
    if (state_d != StRun) begin
      sel_d   = 2'd0;
      dwell_d = 6'd0;
      stim_d  = 3'd0;
    end

    if (state_d == StClear) begin
      sig_d  = 4'd0;
      ones_d = 8'd0;
    end

    s_reset_d = (state_d == StClear);
    busy_d    = (state_d == StClear) || (state_d == StRun);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state_q   <= StIdle;
      sel_q     <= 2'd0;
      dwell_q   <= 6'd0;
      stim_q    <= 3'd0;
      sig_q     <= 4'd0;
      ones_q    <= 8'd0;
      s_reset_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      dwell_q   <= dwell_d;
      stim_q    <= stim_d;
      sig_q     <= sig_d;
      ones_q    <= ones_d;
      s_reset_q <= s_reset_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.dp_s_reset = s_reset_q;
  assign bus.dp_X       = stim_q[2];
  assign bus.dp_Y       = stim_q[1];
  assign bus.dp_Z       = stim_q[0];
  assign bus.S1         = sel_q[1];
  assign bus.S0         = sel_q[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.signature  = sig_q;
  assign bus.ones_count = ones_q;

endmodule

// File: tb/tb_ff_select_sequencer.sv
// Bench for ff_select_sequencer (DWELL=4). T is produced by a small datapath stand-in
// selected by t_mode. Full runs come from a vector table; abort, back-to-back start and
// asynchronous reset are hand-written sequences.
module tb_ff_select_sequencer;

  logic clk;
  logic a_reset;
  int   t_mode;
  int   checks;
  int   errors;

  ff_select_sequencer_if bus ();

  ff_select_sequencer #(
    .DWELL(4)
  ) dut (
    .clk    (clk),
    .a_reset(a_reset),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: T as a function of the sequencer's own drive.
  always_comb begin
    case (t_mode)
      0:       bus.T = 1'b0;
      1:       bus.T = 1'b1;
      2:       bus.T = bus.S1;
      3:       bus.T = bus.dp_Z;
      4:       bus.T = bus.dp_X;
      5:       bus.T = bus.S1 ^ bus.S0;
      default: bus.T = 1'b0;
    endcase
  end

  typedef struct {
    int         mode;
    logic [3:0] sig;
    logic [7:0] ones;
  } vec_t;

  vec_t vecs[6];

  // {dp_s_reset, busy, done, S1, S0, X, Y, Z}
  function automatic logic [7:0] flags();
    return {bus.dp_s_reset, bus.busy, bus.done, bus.S1, bus.S0, bus.dp_X, bus.dp_Y, bus.dp_Z};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the CLEAR cycle; checks CLEAR, all 16 RUN cycles and the DONE cycle.
  task automatic walk(input logic [3:0] sig, input logic [7:0] ones);
    logic [7:0] e;
    chk("clear_flags", flags(), 8'b1100_0000);
    chk("clear_sig", {4'd0, bus.signature}, 8'd0);
    chk("clear_ones", bus.ones_count, 8'd0);
    for (int r = 0; r < 16; r++) begin
      tick();
      e = {3'b010, r[3:2], r[2:0]};
      chk("run_flags", flags(), e);
    end
    tick();
    chk("done_flags", flags(), 8'b0010_0000);
    chk("done_sig", {4'd0, bus.signature}, {4'd0, sig});
    chk("done_ones", bus.ones_count, ones);
  endtask

  task automatic run_full(input logic [3:0] sig, input logic [7:0] ones);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    walk(sig, ones);
    tick();
    chk("idle_flags", flags(), 8'd0);
    chk("idle_sig_hold", {4'd0, bus.signature}, {4'd0, sig});
    chk("idle_ones_hold", bus.ones_count, ones);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    t_mode    = 0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    a_reset   = 1'b0;

    vecs[0] = '{mode: 1, sig: 4'b1111, ones: 8'd16};
    vecs[1] = '{mode: 0, sig: 4'b0000, ones: 8'd0};
    vecs[2] = '{mode: 2, sig: 4'b1100, ones: 8'd8};
    vecs[3] = '{mode: 3, sig: 4'b1111, ones: 8'd8};
    vecs[4] = '{mode: 4, sig: 4'b1010, ones: 8'd8};
    vecs[5] = '{mode: 5, sig: 4'b0110, ones: 8'd8};

    #1 a_reset = 1'b1;
    #2;
    chk("reset_flags", flags(), 8'd0);
    chk("reset_sig", {4'd0, bus.signature}, 8'd0);
    chk("reset_ones", bus.ones_count, 8'd0);
    @(posedge clk);
    #3 a_reset = 1'b0;
    tick();
    chk("idle_after_reset", flags(), 8'd0);

    // Full runs from the table
    foreach (vecs[i]) begin
      t_mode = vecs[i].mode;
      run_full(vecs[i].sig, vecs[i].ones);
    end

    // start held high throughout: second CLEAR directly after DONE
    t_mode    = 1;
    bus.start = 1'b1;
    tick();
    walk(4'b1111, 8'd16);
    tick();
    chk("b2b_clear", flags(), 8'b1100_0000);
    bus.start = 1'b0;
    walk(4'b1111, 8'd16);
    tick();
    chk("b2b_idle", flags(), 8'd0);

    // abort during RUN cycle 6 with T = Z
    t_mode    = 3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("pre_abort_flags", flags(), 8'b0100_1110);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_flags", flags(), 8'd0);
    chk("abort_sig", {4'd0, bus.signature}, 8'h01);
    chk("abort_ones", bus.ones_count, 8'd3);
    tick();
    chk("abort_no_done", flags(), 8'd0);

    // abort in IDLE blocks a simultaneous start
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    chk("abort_blocks_start", flags(), 8'd0);
    bus.abort = 1'b0;
    tick();
    bus.start = 1'b0;
    walk(4'b1111, 8'd8);
    tick();
    chk("post_abort_idle", flags(), 8'd0);

    // asynchronous reset mid-RUN, between edges
    t_mode    = 1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_reset_ones", bus.ones_count, 8'd5);
    chk("pre_reset_sig", {4'd0, bus.signature}, 8'h01);
    #3 a_reset = 1'b1;
    #1;
    chk("areset_flags", flags(), 8'd0);
    chk("areset_sig", {4'd0, bus.signature}, 8'd0);
    chk("areset_ones", bus.ones_count, 8'd0);
    tick();
    chk("areset_held", flags(), 8'd0);
    #2 a_reset = 1'b0;
    tick();
    chk("areset_idle", flags(), 8'd0);
    run_full(4'b1111, 8'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
